dmem_write_buffer: RTL

Posted-write buffer between the pipelined ARM core's data-memory port and a multi-cycle data memory. Stores retire into a small FIFO in one cycle and drain to memory in the background under a req/ack handshake. Loads are forwarded from buffered stores when the address matches, and otherwise go to memory ahead of pending drains. The core is stalled only when the buffer is full or a load must wait for memory.

---
 rtl/dmem_write_buffer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the core data port and a multi-cycle data memory.
// Define WBUF_FORWARD_EN to enable store-to-load forwarding from buffered stores.
module dmem_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic [AW-1:0] ALUResult,
  input  logic [31:0]   WriteData,
  output logic [31:0]   ReadData,
  output logic          Stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = AW - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tag_q  [DEPTH];
  logic [TW-1:0] tag_d  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic          full, push, pop, rd_done, miss_go;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^ALUResult[1:0];

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign push    = MemWrite && !full;
  assign pop     = (state_q == S_WR) && mem_ack;
  assign rd_done = (state_q == S_RD) && mem_ack;

`ifdef WBUF_FORWARD_EN
  // Scan oldest to newest so the newest matching store wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((32'(count_q) > i) && (tag_q[idx] == ALUResult[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign miss_go = MemRead && !fwd_hit;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  // Without comparators a load may only go to memory once the buffer is empty.
  assign miss_go  = MemRead && (count_q == '0);
`endif

  assign Stall    = reset && ((MemWrite && full) || (MemRead && !fwd_hit && !rd_done));
  assign ReadData = !reset  ? '0       :
                    fwd_hit ? fwd_data :
                    rd_done ? mem_rdata : '0;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push) begin
      tag_d[tail_q]  = ALUResult[AW-1:2];
      data_d[tail_q] = WriteData;
      tail_d         = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (miss_go) begin
          state_d    = S_RD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {ALUResult[AW-1:2], 2'b00};
        end else if (count_q != '0) begin
          state_d     = S_WR;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {tag_q[head_q], 2'b00};
          mem_wdata_d = data_q[head_q];
        end
      end
      S_WR, S_RD: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
    end
  end

endmodule
